// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, returned words queued with their PC for decode.
// Optional misaligned-PC fault detection is built when FETCH_ALIGN_CHECK_EN is defined.
module instr_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_advance,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  output logic               fetch_fault,
  output logic [1:0]         state_dbg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // state_dbg encoding: 0 = IDLE, 1 = WAIT, 2 = DROP
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   req_pc;
  logic [ADDR_W-1:0]   pc_mem    [DEPTH];
  logic [INSTR_W-1:0]  instr_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                space;
  logic                fault_block;
  logic                push;
  logic                pop;

  // An outstanding request reserves a FIFO slot so its response can never overflow.
  assign space = ({1'b0, count} + {{CNT_W{1'b0}}, (state != IDLE)}) < (CNT_W + 1)'(DEPTH);

  assign imem_addr  = {pc[ADDR_W-1:2], 2'b00};
  assign imem_req   = reset_n & (state == IDLE) & space & ~flush & ~fault_block;
  assign pc_advance = imem_req & imem_gnt;

  assign push = (state == WAIT) & imem_rvalid & ~flush;
  assign pop  = if_valid & id_ready & ~flush;

  assign if_valid  = (count != '0);
  assign if_instr  = if_valid ? instr_mem[rd_ptr] : '0;
  assign if_pc     = if_valid ? pc_mem[rd_ptr] : '0;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_advance) begin
            state  <= WAIT;
            req_pc <= imem_addr;
          end
        end
        WAIT: begin
          if (imem_rvalid)  state <= IDLE;
          else if (flush)   state <= DROP;
        end
        DROP: begin
          if (imem_rvalid)  state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Payload storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic misaligned;

  assign misaligned  = (pc[1:0] != 2'b00);
  assign fault_block = fault_q | misaligned;
  assign fetch_fault = fault_q;

  // Sticky until a redirect supplies a new PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      fault_q <= 1'b0;
    else if (flush)
      fault_q <= 1'b0;
    else if ((state == IDLE) && space && misaligned)
      fault_q <= 1'b1;
  end
`else
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^pc[1:0];
  assign fault_block   = 1'b0;
  assign fetch_fault   = 1'b0;
`endif

endmodule
